fetch_stage: RTL and testbench

Instruction-fetch stage of the 5-stage integer pipeline. It owns the PC and drives the combinational IMEM read address. It loads the IF/ID pipeline register and applies redirects from decode-stage branch resolution and stalls from the hazard unit. It detects the end-of-program trap (0x44000300), drains the pipeline, and then raises a halted flag.

---
 rtl/fetch_stage_pkg.sv | 13 +
 rtl/fetch_stage_if_id_reg.sv | 36 +++
 rtl/fetch_stage.sv | 96 +++++++++
 tb/tb_fetch_stage.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_stage_pkg.sv
// Shared pipeline encodings: bubble/trap instruction words, instruction width
// and the fetch-state enum used by fetch, decode and the hazard unit.
package fetch_stage_pkg;
  localparam int          INSTR_W       = 32;
  localparam logic [31:0] NOP_INSTR_DEF = 32'h5400_0000;
  localparam logic [31:0] TRAP_HALT_DEF = 32'h4400_0300;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_HALTED = 2'd2
  } fetch_state_t;
endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register: flush injects a bubble, load captures a new
// instruction, otherwise the contents hold.
module if_id_reg
  import fetch_stage_pkg::*;
#(
  parameter logic [INSTR_W-1:0] NOP_INSTR = NOP_INSTR_DEF
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               load,
  input  logic               flush,
  input  logic [INSTR_W-1:0] fetch_instr,
  input  logic [31:0]        fetch_pc_plus4,
  output logic [INSTR_W-1:0] instruction,
  output logic [31:0]        pc_plus4,
  output logic               valid
);

  // A bubble matches the reset contents so downstream never sees stale PCs.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      instruction <= NOP_INSTR;
      pc_plus4    <= 32'd0;
      valid       <= 1'b0;
    end else if (flush) begin
      instruction <= NOP_INSTR;
      pc_plus4    <= 32'd0;
      valid       <= 1'b0;
    end else if (load) begin
      instruction <= fetch_instr;
      pc_plus4    <= fetch_pc_plus4;
      valid       <= 1'b1;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: owns the PC, feeds IF/ID, applies redirects and stalls,
// and drains the pipeline after the end-of-program trap before halting.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR    = NOP_INSTR_DEF,
  parameter logic [31:0] TRAP_HALT    = TRAP_HALT_DEF,
  parameter int          DRAIN_CYCLES = 4
) (
  input  logic        clock,
  input  logic        reset,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_data,
  input  logic        stall,
  input  logic        branch,
  input  logic [31:0] branch_target,
  output logic [31:0] instruction_0,
  output logic [31:0] pc_plus4_0,
  output logic        valid_0,
  output logic        halted,
  output logic [31:0] fetch_count,
  output logic [1:0]  fetch_state
);

  localparam int CNT_W = $clog2(DRAIN_CYCLES + 1);

  fetch_state_t     state;
  logic [31:0]      pc;
  logic [31:0]      pc_next_seq;
  logic [CNT_W-1:0] drain_cnt;
  logic             ifid_load;
  logic             ifid_flush;
  logic             is_trap;

  assign imem_addr   = pc;
  assign pc_next_seq = pc + 32'd4;
  assign fetch_state = state;
  assign is_trap     = (imem_data == TRAP_HALT);

  // In DRAIN a stall freezes IF/ID and the drain counter alike.
  assign ifid_load  = (state == ST_RUN) && !branch && !stall;
  assign ifid_flush = ((state == ST_RUN) && branch) ||
                      ((state == ST_DRAIN) && !stall);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= ST_RUN;
      pc          <= RESET_PC;
      drain_cnt   <= '0;
      halted      <= 1'b0;
      fetch_count <= 32'd0;
    end else begin
      case (state)
        ST_RUN: begin
          if (branch) begin
            pc <= {branch_target[31:2], 2'b00};
          end else if (!stall) begin
            fetch_count <= fetch_count + 32'd1;
            if (is_trap) begin
              state     <= ST_DRAIN;
              drain_cnt <= '0;
            end else begin
              pc <= pc_next_seq;
            end
          end
        end
        ST_DRAIN: begin
          if (!stall) begin
            drain_cnt <= drain_cnt + CNT_W'(1);
            if (drain_cnt == CNT_W'(DRAIN_CYCLES - 1)) begin
              state  <= ST_HALTED;
              halted <= 1'b1;
            end
          end
        end
        default: begin
          halted <= 1'b1;
        end
      endcase
    end
  end

  if_id_reg #(.NOP_INSTR(NOP_INSTR)) u_if_id (
    .clock          (clock),
    .reset          (reset),
    .load           (ifid_load),
    .flush          (ifid_flush),
    .fetch_instr    (imem_data),
    .fetch_pc_plus4 (pc_next_seq),
    .instruction    (instruction_0),
    .pc_plus4       (pc_plus4_0),
    .valid          (valid_0)
  );

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: sequential fetch, stall, branch flush,
// squashed trap, trap drain to halt, and asynchronous reset mid-drain.
module tb_fetch_stage;

  localparam logic [31:0] NOP  = 32'h5400_0000;
  localparam logic [31:0] TRAP = 32'h4400_0300;
  localparam logic [1:0]  S_RUN = 2'd0, S_DRAIN = 2'd1, S_HALT = 2'd2;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic        stall = 1'b0;
  logic        branch = 1'b0;
  logic [31:0] branch_target = 32'd0;
  logic [31:0] instruction_0;
  logic [31:0] pc_plus4_0;
  logic        valid_0;
  logic        halted;
  logic [31:0] fetch_count;
  logic [1:0]  fetch_state;

  logic [31:0] mem [0:255];
  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  // Zero-latency IMEM model.
  assign imem_data = (imem_addr < 32'h400) ? mem[imem_addr[9:2]]
                                           : (32'hDEAD_0000 ^ imem_addr);

  fetch_stage dut (
    .clock         (clock),
    .reset         (reset),
    .imem_addr     (imem_addr),
    .imem_data     (imem_data),
    .stall         (stall),
    .branch        (branch),
    .branch_target (branch_target),
    .instruction_0 (instruction_0),
    .pc_plus4_0    (pc_plus4_0),
    .valid_0       (valid_0),
    .halted        (halted),
    .fetch_count   (fetch_count),
    .fetch_state   (fetch_state)
  );

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'hA000_0000 + i;

    // Reset state
    step();
    step();
    check("rst_pc", imem_addr, 32'h0);
    check("rst_instr", instruction_0, NOP);
    check("rst_pc4", pc_plus4_0, 32'h0);
    check("rst_valid", {31'd0, valid_0}, 32'd0);
    check("rst_halted", {31'd0, halted}, 32'd0);
    check("rst_count", fetch_count, 32'd0);
    check("rst_state", {30'd0, fetch_state}, {30'd0, S_RUN});
    reset = 1'b1;

    // Sequential fetch
    step();
    check("seq1_instr", instruction_0, 32'hA000_0000);
    check("seq1_pc4", pc_plus4_0, 32'h4);
    check("seq1_valid", {31'd0, valid_0}, 32'd1);
    check("seq1_pc", imem_addr, 32'h4);
    step();
    check("seq2_pc", imem_addr, 32'h8);

    // Stall hold at PC=0x8
    stall = 1'b1;
    step();
    step();
    check("stall_pc", imem_addr, 32'h8);
    check("stall_instr", instruction_0, 32'hA000_0001);
    check("stall_pc4", pc_plus4_0, 32'h8);
    check("stall_count", fetch_count, 32'd2);
    stall = 1'b0;
    step();
    check("unstall_instr", instruction_0, 32'hA000_0002);
    check("unstall_pc", imem_addr, 32'hC);
    check("unstall_count", fetch_count, 32'd3);
    step();
    check("seq4_pc", imem_addr, 32'h10);

    // Branch with stall at PC=0x10
    branch = 1'b1; branch_target = 32'h40; stall = 1'b1;
    step();
    check("br_pc", imem_addr, 32'h40);
    check("br_instr", instruction_0, NOP);
    check("br_valid", {31'd0, valid_0}, 32'd0);
    check("br_count", fetch_count, 32'd4);
    branch = 1'b0; stall = 1'b0;
    step();
    check("br_tgt_instr", instruction_0, 32'hA000_0010);
    check("br_tgt_pc4", pc_plus4_0, 32'h44);
    check("br_tgt_pc", imem_addr, 32'h44);

    // Misaligned target is aligned down
    branch = 1'b1; branch_target = 32'h83;
    step();
    check("misalign_pc", imem_addr, 32'h80);

    // Squashed trap at 0x14
    mem[5] = TRAP;
    branch_target = 32'h14;
    step();
    check("sq_at_trap_pc", imem_addr, 32'h14);
    branch_target = 32'h100;
    step();
    check("sq_pc", imem_addr, 32'h100);
    check("sq_state", {30'd0, fetch_state}, {30'd0, S_RUN});
    check("sq_count", fetch_count, 32'd5);
    branch = 1'b0;
    step();
    check("sq_next_instr", instruction_0, 32'hA000_0040);
    check("sq_next_pc", imem_addr, 32'h104);
    check("sq_next_count", fetch_count, 32'd6);

    // Stalled trap is not recognised, then captured
    branch = 1'b1; branch_target = 32'h14;
    step();
    branch = 1'b0; stall = 1'b1;
    step();
    check("stalltrap_state", {30'd0, fetch_state}, {30'd0, S_RUN});
    check("stalltrap_count", fetch_count, 32'd6);
    stall = 1'b0;
    step();
    check("trap_instr", instruction_0, TRAP);
    check("trap_valid", {31'd0, valid_0}, 32'd1);
    check("trap_pc4", pc_plus4_0, 32'h18);
    check("trap_pc", imem_addr, 32'h14);
    check("trap_count", fetch_count, 32'd7);
    check("trap_state", {30'd0, fetch_state}, {30'd0, S_DRAIN});

    // Drain: branch ignored, stall pauses the counter
    branch = 1'b1; branch_target = 32'h200;
    step();
    check("drain_br_pc", imem_addr, 32'h14);
    check("drain_instr", instruction_0, NOP);
    check("drain_valid", {31'd0, valid_0}, 32'd0);
    branch = 1'b0; stall = 1'b1;
    step();
    stall = 1'b0;
    step();
    step();
    check("drain3_halted", {31'd0, halted}, 32'd0);
    step();
    check("drain_halted", {31'd0, halted}, 32'd1);
    check("drain_state", {30'd0, fetch_state}, {30'd0, S_HALT});
    check("drain_count", fetch_count, 32'd7);
    branch = 1'b1; branch_target = 32'h300;
    step();
    check("halt_pc", imem_addr, 32'h14);
    check("halt_instr", instruction_0, NOP);
    check("halt_count", fetch_count, 32'd7);
    branch = 1'b0;

    // Reset from HALTED; trap at 0x8 drains for 4 edges then halts
    reset = 1'b0;
    mem[5] = 32'hA000_0005;
    mem[2] = TRAP;
    #1;
    check("rst_halt_state", {30'd0, fetch_state}, {30'd0, S_RUN});
    check("rst_halt_flag", {31'd0, halted}, 32'd0);
    step();
    reset = 1'b1;
    step();
    step();
    step();
    check("t8_instr", instruction_0, TRAP);
    check("t8_pc", imem_addr, 32'h8);
    check("t8_count", fetch_count, 32'd3);
    for (int i = 0; i < 3; i++) step();
    check("t8_not_yet", {31'd0, halted}, 32'd0);
    step();
    check("t8_halted", {31'd0, halted}, 32'd1);
    check("t8_final_count", fetch_count, 32'd3);
    check("t8_final_pc", imem_addr, 32'h8);

    // Async reset mid-drain
    reset = 1'b0;
    step();
    reset = 1'b1;
    for (int i = 0; i < 4; i++) step();
    check("ar_pre_state", {30'd0, fetch_state}, {30'd0, S_DRAIN});
    #2;
    reset = 1'b0;
    #1;
    check("ar_pc", imem_addr, 32'h0);
    check("ar_state", {30'd0, fetch_state}, {30'd0, S_RUN});
    check("ar_count", fetch_count, 32'd0);
    check("ar_instr", instruction_0, NOP);
    check("ar_valid", {31'd0, valid_0}, 32'd0);
    mem[2] = 32'hA000_0002;
    reset = 1'b1;
    step();
    check("ar_restart_instr", instruction_0, 32'hA000_0000);
    check("ar_restart_pc", imem_addr, 32'h4);
    check("ar_restart_count", fetch_count, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
